// File: rtl/water_level_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : water_level_matrix_scanner
//  Purpose  : Time-multiplexed LED-matrix driver rendering an N-level tank
//             bar graph. Level updates are latched only at frame boundaries
//             so no frame is ever torn. Optional critical-level blinking is
//             enabled by defining the macro WATER_LEVEL_BLINK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module water_level_matrix_scanner #(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int LEVEL_W   = 3,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_valid,
  output logic [COLS-1:0]    col_sel,
  output logic [ROWS-1:0]    row_data,
  output logic               frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W = $clog2(COLS);
  localparam int SH_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [SH_W-1:0]  LVL_MAX  = SH_W'(ROWS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [COL_W-1:0] col_cnt;
  logic [SH_W-1:0]  pending;
  logic [SH_W-1:0]  shown;

  logic             col_end;
  logic             wrap;
  logic [SH_W-1:0]  level_clamped;
  logic [COL_W-1:0] next_col;
  logic [SH_W-1:0]  next_shown;
  logic             next_blank;

  // Tank image: walls fully lit, inner columns lit from the floor up to lvl.
  function automatic logic [ROWS-1:0] image(input logic [COL_W-1:0] col,
                                            input logic [SH_W-1:0]  lvl);
    logic [ROWS-1:0] img;
    for (int r = 0; r < ROWS; r++) begin
      img[r] = (col == '0) || (col == COL_LAST) || (r <= int'(lvl));
    end
    return img;
  endfunction

  assign col_end = (div_cnt == DIV_LAST);
  assign wrap    = col_end && (col_cnt == COL_LAST);

  // Saturate out-of-range requests to the top row.
  always_comb begin
    if (32'(level) > 32'(ROWS - 1)) level_clamped = LVL_MAX;
    else                            level_clamped = SH_W'(level);
  end

  // Next column and next displayed level; the outputs are built from these
  // so column select and row data always change on the same edge.
  always_comb begin
    next_col = col_cnt;
    if (col_end) next_col = (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
    next_shown = shown;
    if (wrap) next_shown = level_valid ? level_clamped : pending;
  end

`ifdef WATER_LEVEL_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic [BLK_W-1:0] next_blink_cnt;
  logic             blink_on;
  logic             next_blink_on;

  // Blink phase advances on frame wraps only while the displayed level is 0.
  always_comb begin
    next_blink_cnt = blink_cnt;
    next_blink_on  = blink_on;
    if (next_shown != '0) begin
      next_blink_cnt = '0;
      next_blink_on  = 1'b1;
    end else if (wrap) begin
      if (blink_cnt == BLK_LAST) begin
        next_blink_cnt = '0;
        next_blink_on  = ~blink_on;
      end else begin
        next_blink_cnt = blink_cnt + 1'b1;
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      blink_cnt <= next_blink_cnt;
      blink_on  <= next_blink_on;
    end
  end

  assign next_blank = ~next_blink_on;
`else
  assign next_blank = 1'b0;
`endif

  // Scan counters, level registers and registered matrix outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      col_cnt     <= '0;
      pending     <= '0;
      shown       <= '0;
      col_sel     <= ~COLS'(1);
      row_data    <= '1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= col_end ? '0 : div_cnt + 1'b1;
      col_cnt     <= next_col;
      if (level_valid) pending <= level_clamped;
      shown       <= next_shown;
      col_sel     <= ~(COLS'(1) << next_col);
      row_data    <= next_blank ? '0 : image(next_col, next_shown);
      frame_start <= wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_water_level_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_water_level_matrix_scanner
//  Purpose  : Self-checking bench for water_level_matrix_scanner. Expected
//             frame images are queued when level strobes are driven and
//             compared column by column as each frame is scanned out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_water_level_matrix_scanner;

  localparam int ROWS      = 7;
  localparam int COLS      = 5;
  localparam int LEVEL_W   = 3;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = COLS * SCAN_DIV;

`ifdef WATER_LEVEL_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [LEVEL_W-1:0] level = '0;
  logic               level_valid = 1'b0;
  logic [COLS-1:0]    col_sel;
  logic [ROWS-1:0]    row_data;
  logic               frame_start;

  typedef struct packed {
    logic [ROWS-1:0] wall;
    logic [ROWS-1:0] inner;
  } frame_exp_t;

  frame_exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  water_level_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .LEVEL_W(LEVEL_W),
    .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .level(level), .level_valid(level_valid),
    .col_sel(col_sel), .row_data(row_data), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Bar graph for an inner column: floor plus rows 1..L, L saturated at 6.
  function automatic logic [ROWS-1:0] bar(input int l);
    int c;
    logic [ROWS-1:0] full;
    c    = (l > ROWS - 1) ? ROWS - 1 : l;
    full = '1;
    return full >> (ROWS - 1 - c);
  endfunction

  task automatic push_frame(input logic [ROWS-1:0] inner, input bit blanked);
    frame_exp_t e;
    if (blanked) begin
      e.wall  = '0;
      e.inner = '0;
    end else begin
      e.wall  = '1;
      e.inner = inner;
    end
    exp_q.push_back(e);
  endtask

  // Apply reset, release it and check the start-up scan timing.
  task automatic do_reset();
    logic [COLS-1:0] sel0;
    logic [COLS-1:0] sel1;
    sel0 = 5'b11110;
    sel1 = 5'b11101;
    reset = 1'b1;
    level_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_col_sel", 32'(col_sel), 32'(sel0));
    check_val("rst_row_data", 32'(row_data), 32'h7F);
    check_val("rst_frame_start", 32'(frame_start), 32'h0);
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (i == SCAN_DIV - 1) check_val("col0_hold", 32'(col_sel), 32'(sel0));
      if (i == SCAN_DIV) begin
        check_val("col1_sel", 32'(col_sel), 32'(sel1));
        check_val("col1_floor", 32'(row_data), 32'(bar(0)));
      end
      if (i == FRAME - 1) check_val("fs_early", 32'(frame_start), 32'h0);
      if (i == FRAME) check_val("fs_first", 32'(frame_start), 32'h1);
    end
  endtask

  // Scan one frame starting in its first cycle; strobe levels at cycle
  // offsets k0/k1 (-1 = none) and compare against the queued image.
  task automatic run_frame(input int k0, input logic [LEVEL_W-1:0] l0,
                           input int k1, input logic [LEVEL_W-1:0] l1);
    frame_exp_t e;
    logic [COLS-1:0] sel;
    logic [ROWS-1:0] rows;
    e.wall  = '1;
    e.inner = '0;
    if (exp_q.size() == 0) check_val("scoreboard_empty", 32'h1, 32'h0);
    else e = exp_q.pop_front();
    for (int k = 0; k < FRAME; k++) begin
      int c;
      c = k / SCAN_DIV;
      if (k % SCAN_DIV == 0) begin
        sel  = ~(COLS'(1) << c);
        rows = (c == 0 || c == COLS - 1) ? e.wall : e.inner;
        check_val($sformatf("col_sel_c%0d", c), 32'(col_sel), 32'(sel));
        check_val($sformatf("row_data_c%0d", c), 32'(row_data), 32'(rows));
      end
      if (k == FRAME / 2) check_val("fs_mid", 32'(frame_start), 32'h0);
      if (k == k0) begin
        level = l0; level_valid = 1'b1;
      end else if (k == k1) begin
        level = l1; level_valid = 1'b1;
      end else begin
        level_valid = 1'b0;
      end
      @(negedge clk);
    end
    level_valid = 1'b0;
    check_val("fs_period", 32'(frame_start), 32'h1);
  endtask

  initial begin
    do_reset();
    push_frame(bar(0), 1'b0);           // first full frame still shows level 0
    push_frame(bar(3), 1'b0);
    run_frame(7, 3'd3, -1, 3'd0);       // mid-frame strobe: takes effect next frame
    push_frame(bar(5), 1'b0);
    run_frame(2, 3'd3, 13, 3'd5);       // last strobe wins
    push_frame(bar(7), 1'b0);
    run_frame(10, 3'd7, -1, 3'd0);      // 7 saturates to 6
    push_frame(bar(2), 1'b0);
    run_frame(FRAME - 1, 3'd2, -1, 3'd0); // strobe on wrap cycle bypasses
    push_frame(bar(0), 1'b0);
    run_frame(5, 3'd0, -1, 3'd0);
    push_frame(bar(0), BLINK);
    run_frame(-1, 3'd0, -1, 3'd0);      // critical, first lit frame
    push_frame(bar(0), BLINK);
    run_frame(-1, 3'd0, -1, 3'd0);
    push_frame(bar(1), 1'b0);
    run_frame(8, 3'd1, -1, 3'd0);       // leaving critical relights at once
    run_frame(-1, 3'd0, -1, 3'd0);
    check_val("queue_drained", 32'(exp_q.size()), 32'h0);
    repeat (7) @(negedge clk);
    do_reset();                         // mid-frame reset
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
